lfsr_seq_ctrl: RTL

//  Request/response sequencer for an 8-bit XNOR LFSR (taps 8,6,5,4). Accepts a job (seed, mode, step

---
 rtl/lfsr_pkg.sv | 32 +++
 rtl/lfsr_seq_ctrl_if.sv | 32 +++
 rtl/lfsr_core.sv | 24 ++
 rtl/lfsr_seq_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sequencer: LFSR geometry, step function,
// controller state encoding and response error codes.
package lfsr_pkg;

  localparam int LFSR_W = 8;

  // XNOR feedback taps 8,6,5,4 map to state bits 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 8'hB8;
  localparam logic [LFSR_W-1:0] LOCKUP_STATE = 8'hFF;

  localparam logic MODE_RUN    = 1'b0;
  localparam logic MODE_PERIOD = 1'b1;

  localparam logic [1:0] ERR_OK          = 2'd0;
  localparam logic [1:0] ERR_LOCKUP_SEED = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT     = 2'd2;
  localparam logic [1:0] ERR_ABORTED     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic fb;
    fb = ~(^(s & LFSR_TAPS));
    return {s[LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// Job request / response bundle between a job issuer (master) and the
// LFSR sequencer (slave).
interface lfsr_seq_ctrl_if
  import lfsr_pkg::*;
#(
  parameter int STEP_W = 16
);

  logic              req_valid;
  logic              req_ready;
  logic [LFSR_W-1:0] req_seed;
  logic              req_mode;
  logic [STEP_W-1:0] req_steps;
  logic              abort;
  logic              busy;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [LFSR_W-1:0] rsp_value;
  logic [STEP_W-1:0] rsp_count;
  logic [1:0]        rsp_err;

  modport master (
    output req_valid, req_seed, req_mode, req_steps, abort, rsp_ready,
    input  req_ready, busy, rsp_valid, rsp_value, rsp_count, rsp_err
  );

  modport slave (
    input  req_valid, req_seed, req_mode, req_steps, abort, rsp_ready,
    output req_ready, busy, rsp_valid, rsp_value, rsp_count, rsp_err
  );

endinterface

// File: rtl/lfsr_core.sv
// 8-bit XNOR LFSR register. seed_en loads the seed and takes priority over
// enable; with neither asserted the state holds.
module lfsr_core
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_en,
  input  logic              enable,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
    end else if (seed_en) begin
      state <= seed;
    end else if (enable) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Job sequencer for the LFSR: accepts a seed/mode/step-count job, runs the
// LFSR for N steps or one full period, and holds the result until consumed.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int STEP_W     = 16,
  parameter int MAX_PERIOD = 256
) (
  input logic            clk,
  input logic            rst,
  lfsr_seq_ctrl_if.slave bus
);

  localparam logic [STEP_W-1:0] MAX_CNT = STEP_W'(MAX_PERIOD);

  state_t            state_q, state_d;
  logic [1:0]        err_q, err_d;
  logic [STEP_W-1:0] count_q;
  logic [STEP_W-1:0] cnt_inc;
  logic [LFSR_W-1:0] seed_q;
  logic              mode_q;
  logic [STEP_W-1:0] steps_q;

  logic              accept;
  logic              seed_en;
  logic              lfsr_en;
  logic              cnt_clr;
  logic              cnt_step;
  logic [LFSR_W-1:0] lfsr_state;
  logic [LFSR_W-1:0] lfsr_nxt;

  logic              run_hit;
  logic              per_hit;
  logic              per_timeout;

  lfsr_core u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .seed_en (seed_en),
    .enable  (lfsr_en),
    .seed    (seed_q),
    .state   (lfsr_state)
  );

  // Terminal conditions are evaluated on the post-step values so the
  // response reflects the step taken on the finishing edge.
  assign cnt_inc     = count_q + STEP_W'(1);
  assign lfsr_nxt    = lfsr_step(lfsr_state);
  assign run_hit     = (mode_q == MODE_RUN)    && (cnt_inc == steps_q);
  assign per_hit     = (mode_q == MODE_PERIOD) && (lfsr_nxt == seed_q);
  assign per_timeout = (mode_q == MODE_PERIOD) && (cnt_inc == MAX_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (cnt_clr) begin
      count_q <= '0;
    end else if (cnt_step) begin
      count_q <= cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      seed_q  <= bus.req_seed;
      mode_q  <= bus.req_mode;
      steps_q <= bus.req_steps;
    end
  end

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    accept   = 1'b0;
    seed_en  = 1'b0;
    lfsr_en  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        seed_en = 1'b1;
        cnt_clr = 1'b1;
        err_d   = ERR_OK;
        state_d = ST_RUN;
        // Lockup seed and zero-length jobs finish here and beat a concurrent abort
        if (seed_q == LOCKUP_STATE) begin
          state_d = ST_DONE;
          err_d   = ERR_LOCKUP_SEED;
        end else if ((mode_q == MODE_RUN) && (steps_q == '0)) begin
          state_d = ST_DONE;
        end else if (bus.abort) begin
          state_d = ST_DONE;
          err_d   = ERR_ABORTED;
        end
      end
      ST_RUN: begin
        if (run_hit || per_hit) begin
          lfsr_en  = 1'b1;
          cnt_step = 1'b1;
          state_d  = ST_DONE;
          err_d    = ERR_OK;
        end else if (per_timeout) begin
          lfsr_en  = 1'b1;
          cnt_step = 1'b1;
          state_d  = ST_DONE;
          err_d    = ERR_TIMEOUT;
        end else if (bus.abort) begin
          state_d  = ST_DONE;
          err_d    = ERR_ABORTED;
        end else begin
          lfsr_en  = 1'b1;
          cnt_step = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_DONE);
  assign bus.rsp_value = lfsr_state;
  assign bus.rsp_count = count_q;
  assign bus.rsp_err   = err_q;

endmodule
